// File: rtl/slv_i2c_regs_if.sv
// slv_i2c_regs_if: I2C pin side and local register port of slv_i2c_regs.
// sda is the resolved pin level; sda_oe=1 pulls the open-drain line low (the pad buffer sits at chip top).
interface slv_i2c_regs_if #(
    parameter int PTR_W   = 4,
    parameter int DATA_SZ = 8
);
    logic               scl;
    logic               sda;
    logic               sda_oe;
    logic [PTR_W-1:0]   reg_sel;
    logic [DATA_SZ-1:0] reg_data;
    logic               wr_stb;
    logic [PTR_W-1:0]   wr_addr;
    logic [DATA_SZ-1:0] wr_data;
    logic               busy;
    logic               mstr_nack;
    logic               gcall_stb;
    logic [DATA_SZ-1:0] gcall_data;

    modport slave (
        input  scl, sda, reg_sel,
        output sda_oe, reg_data, wr_stb, wr_addr, wr_data, busy, mstr_nack, gcall_stb, gcall_data
    );
    modport master (
        output scl, reg_sel,
        input  sda, sda_oe, reg_data, wr_stb, wr_addr, wr_data, busy, mstr_nack, gcall_stb, gcall_data
    );
endinterface

// File: rtl/slv_i2c_regs.sv
// slv_i2c_regs: I2C slave with register file, register pointer, auto-increment and local read-back port.
// Define I2C_GCALL_EN to ACK general-call (address byte 8'h00) and report its data bytes on gcall_stb/gcall_data.
module slv_i2c_regs #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         DATA_SZ  = 8,
    parameter int         REG_NUM  = 16,
    parameter int         FILT_LEN = 3
) (
    input logic           clk,
    input logic           rst,
    slv_i2c_regs_if.slave bus
);
    localparam int PTR_W = $clog2(REG_NUM);

    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_P} state_t;

    state_t             state;
    logic [1:0]         scl_s, sda_s;
    logic [3:0]         scl_c, sda_c;
    logic               scl_f, sda_f, scl_p, sda_p;
    logic [DATA_SZ-1:0] regs [REG_NUM];
    logic [PTR_W-1:0]   ptr;
    logic [6:0]         rx, tx;
    logic [2:0]         bit_cnt;
    logic               ack_on, rw, gc;
    logic               scl_rise, scl_fall, start_c, stop_c, last, hit, gcall_hit;
    logic [7:0]         byte_in, rd_byte;

    // A level is accepted only after the synchronised input has differed from it for FILT_LEN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_c <= '0;
            sda_c <= '0;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_s <= {scl_s[0], bus.scl};
            sda_s <= {sda_s[0], bus.sda};
            scl_p <= scl_f;
            sda_p <= sda_f;
            scl_c <= (scl_s[1] == scl_f || scl_c == 4'(FILT_LEN - 1)) ? '0 : scl_c + 4'd1;
            sda_c <= (sda_s[1] == sda_f || sda_c == 4'(FILT_LEN - 1)) ? '0 : sda_c + 4'd1;
            if (scl_s[1] != scl_f && scl_c == 4'(FILT_LEN - 1)) scl_f <= scl_s[1];
            if (sda_s[1] != sda_f && sda_c == 4'(FILT_LEN - 1)) sda_f <= sda_s[1];
        end
    end

    assign scl_rise = scl_f & ~scl_p;
    assign scl_fall = ~scl_f & scl_p;
    assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;
    assign byte_in  = {rx, sda_f};
    assign rd_byte  = 8'(regs[ptr]);
    assign last     = bit_cnt == 3'd7;
`ifdef I2C_GCALL_EN
    assign gcall_hit = byte_in == 8'h00;
`else
    assign gcall_hit = 1'b0;
`endif
    assign hit = byte_in[7:1] == SLV_ADDR || gcall_hit;
    assign bus.reg_data = regs[bus.reg_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            rx             <= '0;
            tx             <= '0;
            bit_cnt        <= '0;
            ack_on         <= 1'b0;
            rw             <= 1'b0;
            gc             <= 1'b0;
            bus.sda_oe     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.wr_stb     <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.mstr_nack  <= 1'b0;
            bus.gcall_stb  <= 1'b0;
            bus.gcall_data <= '0;
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else begin
            bus.wr_stb    <= 1'b0;
            bus.mstr_nack <= 1'b0;
            bus.gcall_stb <= 1'b0;
            if (start_c) begin
                state      <= ADDR;
                bit_cnt    <= '0;
                ack_on     <= 1'b0;
                bus.sda_oe <= 1'b0;
            end else if (stop_c) begin
                state      <= IDLE;
                ack_on     <= 1'b0;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
            end else if (scl_rise) begin
                rx      <= byte_in[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                case (state)
                    ADDR: if (last) begin
                        state    <= hit ? ADDR_ACK : WAIT_P;
                        bus.busy <= bus.busy & hit;
                        rw       <= byte_in[0];
                        gc       <= gcall_hit;
                    end
                    PTR: if (last) begin
                        ptr   <= byte_in[PTR_W-1:0];
                        state <= PTR_ACK;
                    end
                    WR: if (last) begin
                        state <= WR_ACK;
                        if (gc) begin
                            bus.gcall_stb  <= 1'b1;
                            bus.gcall_data <= DATA_SZ'(byte_in);
                        end else begin
                            regs[ptr]   <= DATA_SZ'(byte_in);
                            bus.wr_stb  <= 1'b1;
                            bus.wr_addr <= ptr;
                            bus.wr_data <= DATA_SZ'(byte_in);
                            ptr         <= ptr + PTR_W'(1);
                        end
                    end
                    RD: if (last) begin
                        state <= RD_ACK;
                        ptr   <= ptr + PTR_W'(1);
                    end
                    RD_ACK: if (sda_f) begin
                        bus.mstr_nack <= 1'b1;
                        state         <= WAIT_P;
                    end else begin
                        ack_on <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    // First fall starts the ACK pulse, second fall ends it and enters the next phase.
                    ADDR_ACK, PTR_ACK, WR_ACK: begin
                        ack_on     <= !ack_on;
                        bus.busy   <= 1'b1;
                        bus.sda_oe <= !ack_on || (state == ADDR_ACK && rw && !rd_byte[7]);
                        tx         <= rd_byte[6:0];
                        bit_cnt    <= '0;
                        if (ack_on) state <= (state != ADDR_ACK || gc) ? WR : (rw ? RD : PTR);
                    end
                    RD: begin
                        tx         <= {tx[5:0], 1'b0};
                        bus.sda_oe <= !tx[6];
                    end
                    RD_ACK: if (ack_on) begin
                        state      <= RD;
                        ack_on     <= 1'b0;
                        bit_cnt    <= '0;
                        tx         <= rd_byte[6:0];
                        bus.sda_oe <= !rd_byte[7];
                    end else begin
                        bus.sda_oe <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_slv_i2c_regs.sv
// tb_slv_i2c_regs: directed bench for slv_i2c_regs acting as the I2C master on a resolved open-drain SDA.
// Table of write transactions plus hand-written read, glitch, reset and general-call sequences.
module tb_slv_i2c_regs;
    localparam int Q = 12;
`ifdef I2C_GCALL_EN
    localparam logic GC = 1'b1;
`else
    localparam logic GC = 1'b0;
`endif

    typedef struct {
        logic [7:0] dev, ptr, d0, d1;
        logic       ack;
        logic [3:0] a0, a1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_low = 1'b0;
    logic clr = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [3:0] wa[$];
    logic [7:0] wd[$];
    int nack_cnt = 0;
    int gc_cnt = 0;
    logic [7:0] gc_last = 8'h00;
    logic oe_seen = 1'b0;

    slv_i2c_regs_if #(.PTR_W(4), .DATA_SZ(8)) bus ();
    slv_i2c_regs #(.SLV_ADDR(7'h50), .DATA_SZ(8), .REG_NUM(16), .FILT_LEN(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.sda = ~(bus.sda_oe | m_low);
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr) begin
            wa.delete();
            wd.delete();
            nack_cnt = 0;
            gc_cnt = 0;
            gc_last = 8'h00;
            oe_seen = 1'b0;
        end else begin
            if (bus.wr_stb) begin
                wa.push_back(bus.wr_addr);
                wd.push_back(bus.wr_data);
            end
            if (bus.mstr_nack) nack_cnt++;
            if (bus.gcall_stb) begin
                gc_cnt++;
                gc_last = bus.gcall_data;
            end
            oe_seen = oe_seen | bus.sda_oe;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
    endtask

    task automatic put_bit(input logic b);
        m_low = ~b;
        tick(Q);
        bus.scl = 1'b1;
        tick(2 * Q);
        bus.scl = 1'b0;
        tick(Q);
    endtask

    task automatic get_bit(output logic b);
        m_low = 1'b0;
        tick(Q);
        bus.scl = 1'b1;
        tick(Q);
        b = bus.sda;
        tick(Q);
        bus.scl = 1'b0;
        tick(Q);
    endtask

    task automatic send(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic recv(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    // Works both from idle and as a repeated START with SCL low.
    task automatic start_c();
        m_low = 1'b0;
        tick(Q);
        bus.scl = 1'b1;
        tick(Q);
        m_low = 1'b1;
        tick(Q);
        bus.scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_c();
        m_low = 1'b1;
        tick(Q);
        bus.scl = 1'b1;
        tick(Q);
        m_low = 1'b0;
        tick(2 * Q);
    endtask

    initial begin
        vec_t v[5];
        logic a, b, c, d;
        logic [7:0] r0, r1;
        v[0] = '{8'hA0, 8'h13, 8'h5C, 8'h6D, 1'b1, 4'd3, 4'd4};
        v[1] = '{8'hA0, 8'h03, 8'h11, 8'h22, 1'b1, 4'd3, 4'd4};
        v[2] = '{8'hA0, 8'h0F, 8'hAA, 8'hBB, 1'b1, 4'd15, 4'd0};
        v[3] = '{8'hB0, 8'h55, 8'h12, 8'h34, 1'b0, 4'd0, 4'd0};
        v[4] = '{8'hA2, 8'h01, 8'h99, 8'h98, 1'b0, 4'd0, 4'd0};
        bus.scl = 1'b1;
        bus.reg_sel = 4'd3;
        tick(4);
        chk("reset sda_oe", 32'(bus.sda_oe), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset wr_stb", 32'(bus.wr_stb), 0);
        chk("reset mstr_nack", 32'(bus.mstr_nack), 0);
        chk("reset gcall_stb", 32'(bus.gcall_stb), 0);
        chk("reset reg_data", 32'(bus.reg_data), 0);
        rst = 1'b0;
        tick(10);

        for (int k = 0; k < 5; k++) begin
            clear_mon();
            start_c();
            send(v[k].dev, a);
            chk($sformatf("v%0d addr ack", k), 32'(a), 32'(v[k].ack));
            chk($sformatf("v%0d busy in xfer", k), 32'(bus.busy), 32'(v[k].ack));
            send(v[k].ptr, b);
            send(v[k].d0, c);
            send(v[k].d1, d);
            chk($sformatf("v%0d data acks", k), {29'd0, b, c, d}, {29'd0, {3{v[k].ack}}});
            stop_c();
            chk($sformatf("v%0d busy after P", k), 32'(bus.busy), 0);
            chk($sformatf("v%0d sda released", k), 32'(bus.sda_oe), 0);
            chk($sformatf("v%0d sda ever driven", k), 32'(oe_seen), 32'(v[k].ack));
            chk($sformatf("v%0d wr_stb count", k), 32'(wa.size()), v[k].ack ? 2 : 0);
            if (v[k].ack) begin
                chk($sformatf("v%0d wr_addr0", k), 32'(wa[0]), 32'(v[k].a0));
                chk($sformatf("v%0d wr_data0", k), 32'(wd[0]), 32'(v[k].d0));
                chk($sformatf("v%0d wr_addr1", k), 32'(wa[1]), 32'(v[k].a1));
                chk($sformatf("v%0d wr_data1", k), 32'(wd[1]), 32'(v[k].d1));
                bus.reg_sel = v[k].a0;
                tick(1);
                chk($sformatf("v%0d readback0", k), 32'(bus.reg_data), 32'(v[k].d0));
                bus.reg_sel = v[k].a1;
                tick(1);
                chk($sformatf("v%0d readback1", k), 32'(bus.reg_data), 32'(v[k].d1));
            end
        end

        clear_mon();
        start_c();
        send(8'hA0, a);
        send(8'h03, b);
        start_c();
        send(8'hA1, c);
        chk("rd acks", {29'd0, a, b, c}, 32'h7);
        recv(r0, 1'b0);
        recv(r1, 1'b1);
        chk("rd byte0", 32'(r0), 32'h11);
        chk("rd byte1", 32'(r1), 32'h22);
        stop_c();
        chk("rd nack pulses", 32'(nack_cnt), 1);
        chk("rd sda released", 32'(bus.sda_oe), 0);
        chk("rd busy after P", 32'(bus.busy), 0);

        start_c();
        send(8'hA0, a);
        send(8'h0F, b);
        start_c();
        send(8'hA1, c);
        recv(r0, 1'b0);
        recv(r1, 1'b1);
        stop_c();
        chk("rd wrap byte15", 32'(r0), 32'hAA);
        chk("rd wrap byte0", 32'(r1), 32'hBB);

        clear_mon();
        start_c();
        send(8'hA0, a);
        send(8'h09, b);
        bus.scl = 1'b1;
        tick(1);
        bus.scl = 1'b0;
        tick(Q);
        send(8'h3C, c);
        stop_c();
        chk("glitch ack", 32'(c), 1);
        chk("glitch stb count", 32'(wa.size()), 1);
        chk("glitch wr_addr", 32'(wa[0]), 9);
        chk("glitch wr_data", 32'(wd[0]), 32'h3C);

        start_c();
        for (int i = 7; i >= 0; i--) put_bit(v[1].dev[i]);
        chk("mid-ack sda driven", 32'(bus.sda_oe), 1);
        chk("mid-ack busy", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("reset mid-ack sda", 32'(bus.sda_oe), 0);
        chk("reset mid-ack busy", 32'(bus.busy), 0);
        m_low = 1'b0;
        bus.scl = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(10);
        bus.reg_sel = 4'd9;
        tick(1);
        chk("reset clears regs", 32'(bus.reg_data), 0);

        clear_mon();
        start_c();
        send(8'h00, a);
        send(8'h5A, b);
        stop_c();
        chk("gcall addr ack", 32'(a), 32'(GC));
        chk("gcall data ack", 32'(b), 32'(GC));
        chk("gcall stb count", 32'(gc_cnt), 32'(GC));
        chk("gcall data", 32'(gc_last), GC ? 32'h5A : 32'h0);
        chk("gcall no reg write", 32'(wa.size()), 0);
        start_c();
        send(8'h01, a);
        stop_c();
        chk("addr 0x01 nack", 32'(a), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
